alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_issue_decode.sv | 22 ++
 rtl/alu_cmd_issuer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ==== alu_pkg : ALU command encodings, issue latencies, issuer FSM state ====
// ==== rev 1.0 ==============================================================
package alu_pkg;

  typedef enum logic [3:0] {
    CMD_ADD        = 4'd0,
    CMD_SUB        = 4'd1,
    CMD_ADD_CIN    = 4'd2,
    CMD_SUB_CIN    = 4'd3,
    CMD_INC_A      = 4'd4,
    CMD_DEC_A      = 4'd5,
    CMD_INC_B      = 4'd6,
    CMD_DEC_B      = 4'd7,
    CMD_CMP        = 4'd8,
    CMD_MUL_INC    = 4'd9,
    CMD_MUL_SHL    = 4'd10,
    CMD_ADD_SIGNED = 4'd11,
    CMD_SUB_SIGNED = 4'd12
  } arith_cmd_t;

  typedef enum logic [3:0] {
    LOG_AND    = 4'd0,
    LOG_NAND   = 4'd1,
    LOG_OR     = 4'd2,
    LOG_NOR    = 4'd3,
    LOG_XOR    = 4'd4,
    LOG_XNOR   = 4'd5,
    LOG_NOT_A  = 4'd6,
    LOG_NOT_B  = 4'd7,
    LOG_SHR1_A = 4'd8,
    LOG_SHL1_A = 4'd9,
    LOG_SHR1_B = 4'd10,
    LOG_SHL1_B = 4'd11,
    LOG_ROL    = 4'd12,
    LOG_ROR    = 4'd13
  } logic_cmd_t;

  localparam int LAT_NORMAL = 2;
  localparam int LAT_MULT   = 3;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ==== alu_issue_decode : command legality and ALU latency class ============
// ==== rev 1.0 ==============================================================
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic             mode,
  input  logic [3:0]       cmd,
  output logic             legal,
  output logic [CNT_W-1:0] lat
);

  always_comb begin
    legal = mode ? (cmd <= CMD_SUB_SIGNED) : (cmd <= LOG_ROR);
    lat   = CNT_W'(LAT_NORMAL);
    if (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) begin
      lat = CNT_W'(LAT_MULT);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ==== alu_cmd_issuer : one-outstanding request/response wrapper for an ALU ==
// ==== rev 1.0 ==============================================================
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mode,
  input  logic [3:0]      req_cmd,
  input  logic            req_cin,
  input  logic [1:0]      req_inp_valid,
  input  logic [N-1:0]    req_opa,
  input  logic [N-1:0]    req_opb,
  input  logic [TAGW-1:0] req_tag,
  output logic            alu_ce,
  output logic            alu_mode,
  output logic [3:0]      alu_cmd,
  output logic            alu_cin,
  output logic [1:0]      alu_inp_valid,
  output logic [N-1:0]    alu_opa,
  output logic [N-1:0]    alu_opb,
  input  logic [2*N-1:0]  alu_res,
  input  logic            alu_err,
  input  logic            alu_oflow,
  input  logic            alu_cout,
  input  logic            alu_g,
  input  logic            alu_l,
  input  logic            alu_e,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*N-1:0]  rsp_res,
  output logic            rsp_err,
  output logic            rsp_oflow,
  output logic            rsp_cout,
  output logic            rsp_g,
  output logic            rsp_l,
  output logic            rsp_e,
  output logic            rsp_illegal,
  output logic [TAGW-1:0] rsp_tag
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dec_legal;
  logic [CNT_W-1:0] dec_lat;
  logic             accept;
  logic             rsp_fire;
  logic             capture;

  alu_issue_decode u_decode (
    .mode  (req_mode),
    .cmd   (req_cmd),
    .legal (dec_legal),
    .lat   (dec_lat)
  );

  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_valid = (state == ST_RESP);
  assign alu_ce    = (state == ST_BUSY);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  // Last BUSY cycle: the counter steps to zero on this edge, so BUSY lasts exactly the loaded latency.
  assign capture   = alu_ce && (cnt <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)   state_nxt = dec_legal ? ST_BUSY : ST_RESP;
      ST_BUSY: if (capture)  state_nxt = ST_RESP;
      ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      alu_mode      <= 1'b0;
      alu_cmd       <= '0;
      alu_cin       <= 1'b0;
      alu_inp_valid <= '0;
      alu_opa       <= '0;
      alu_opb       <= '0;
      rsp_res       <= '0;
      rsp_err       <= 1'b0;
      rsp_oflow     <= 1'b0;
      rsp_cout      <= 1'b0;
      rsp_g         <= 1'b0;
      rsp_l         <= 1'b0;
      rsp_e         <= 1'b0;
      rsp_illegal   <= 1'b0;
      rsp_tag       <= '0;
    end else begin
      if (accept) begin
        rsp_tag     <= req_tag;
        rsp_illegal <= !dec_legal;
        // Illegal commands never reach the ALU, so its input fields keep their previous values.
        if (dec_legal) begin
          cnt           <= dec_lat;
          alu_mode      <= req_mode;
          alu_cmd       <= req_cmd;
          alu_cin       <= req_cin;
          alu_inp_valid <= req_inp_valid;
          alu_opa       <= req_opa;
          alu_opb       <= req_opb;
        end else begin
          rsp_res   <= '0;
          rsp_err   <= 1'b0;
          rsp_oflow <= 1'b0;
          rsp_cout  <= 1'b0;
          rsp_g     <= 1'b0;
          rsp_l     <= 1'b0;
          rsp_e     <= 1'b0;
        end
      end
      if (alu_ce) begin
        cnt <= cnt - CNT_W'(1);
        if (capture) begin
          rsp_res   <= alu_res;
          rsp_err   <= alu_err;
          rsp_oflow <= alu_oflow;
          rsp_cout  <= alu_cout;
          rsp_g     <= alu_g;
          rsp_l     <= alu_l;
          rsp_e     <= alu_e;
        end
      end
    end
  end

endmodule
`default_nettype wire
